// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester packet credits for router output ports.
// Define WRR_ARB_LOCK_EN to hold a grant across multi-flit packets (TAIL honoured).
module wrr_arbiter #(
    parameter int unsigned NR    = 5,
    parameter int unsigned WW    = 4,
    parameter int unsigned PTR_W = $clog2(NR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NR-1:0]    req,
    input  logic [NR-1:0]    tail,
    input  logic [NR*WW-1:0] weight,
    output logic [NR-1:0]    grt,
    output logic             grt_vld,
    output logic [PTR_W-1:0] grt_idx
);

    logic [PTR_W-1:0] ptr_q;
    logic [WW-1:0]    credit_q [NR];
    logic [WW-1:0]    wt_eff   [NR];
    logic [NR-1:0]    elig;
    logic [NR-1:0]    cand;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;
    logic [PTR_W-1:0] win_idx;
    logic             win_vld;
    logic             gnt_evt;
    logic             pkt_end;
    logic             reload;

    // Fall back to the raw request vector once every requester has spent its credits.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NR; i++) begin
            wt_eff[i] = (weight[i*WW +: WW] == '0) ? WW'(1) : weight[i*WW +: WW];
            elig[i]   = req[i] && (credit_q[i] != '0);
        end
        cand     = (elig != '0) ? elig : req;
        pick_vld = (cand != '0);
        pick_idx = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (cand[i]) pick_idx = PTR_W'(i);
        end
        for (int i = NR - 1; i >= 0; i--) begin
            if (cand[i] && (i >= int'(ptr_q))) pick_idx = PTR_W'(i);
        end
    end

`ifdef WRR_ARB_LOCK_EN
    typedef enum logic {StIdle, StHold} st_e;
    st_e              st_q;
    logic [PTR_W-1:0] owner_q;

    // While a packet is in flight only its owner may win; a dropped request is a bubble.
    always_comb begin
        if (st_q == StHold) begin
            win_vld = req[owner_q];
            win_idx = owner_q;
        end else begin
            win_vld = pick_vld;
            win_idx = pick_idx;
        end
        if (rst) begin
            win_vld = 1'b0;
            win_idx = '0;
        end
    end

    assign pkt_end = gnt_evt & tail[win_idx];
`else
    logic unused_tail;
    assign unused_tail = ^tail;

    always_comb begin
        win_vld = pick_vld & ~rst;
        win_idx = rst ? '0 : pick_idx;
    end

    assign pkt_end = gnt_evt;
`endif

    assign gnt_evt = win_vld & en;
    assign grt     = win_vld ? (NR'(1) << win_idx) : '0;
    assign grt_vld = win_vld;
    assign grt_idx = win_vld ? win_idx : '0;
    // A winner with no credit can only have been picked from the exhausted pool.
    assign reload  = (credit_q[win_idx] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < NR; i++) credit_q[i] <= wt_eff[i];
`ifdef WRR_ARB_LOCK_EN
            st_q    <= StIdle;
            owner_q <= '0;
`endif
        end else if (gnt_evt) begin
            if (pkt_end) begin
                ptr_q <= (win_idx == PTR_W'(NR - 1)) ? '0 : win_idx + PTR_W'(1);
                if (reload) begin
                    for (int i = 0; i < NR; i++) credit_q[i] <= wt_eff[i];
                    credit_q[win_idx] <= wt_eff[win_idx] - WW'(1);
                end else begin
                    credit_q[win_idx] <= credit_q[win_idx] - WW'(1);
                end
            end
`ifdef WRR_ARB_LOCK_EN
            if (pkt_end) begin
                st_q <= StIdle;
            end else begin
                st_q    <= StHold;
                owner_q <= win_idx;
            end
`endif
        end
    end

endmodule
